// File: rtl/sys_ctrl_mb.sv
// System controller: decodes UART command frames into RF writes/reads and ALU jobs, returns results to the TX FIFO.
// Optional idle-wait timeout is enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_mb #(
  parameter int FRAME_WIDTH         = 8,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int OUT_BYTES           = ALU_DATA_WIDTH / FRAME_WIDTH,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int REG_FILE_DEPTH      = 16,
  parameter int REG_FILE_ADDR_WIDTH = $clog2(REG_FILE_DEPTH),
  parameter int OPA_ADDR            = 0,
  parameter int OPB_ADDR            = 1,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [FRAME_WIDTH-1:0]         RX_P_DATA,
  input  logic                           RX_P_VLD,
  input  logic [ALU_DATA_WIDTH-1:0]      ALU_OUT,
  input  logic                           OUT_VALID,
  input  logic [FRAME_WIDTH-1:0]         RdData,
  input  logic                           RdData_Valid,
  input  logic                           FIFO_FULL,
  output logic [ALU_FUNC_WIDTH-1:0]      ALU_FUNC,
  output logic                           ALU_EN,
  output logic                           CLK_EN,
  output logic [REG_FILE_ADDR_WIDTH-1:0] RF_ADDR,
  output logic                           WrEn,
  output logic                           RdEn,
  output logic [FRAME_WIDTH-1:0]         WrData,
  output logic                           WR_INC,
  output logic                           clk_div_en,
  output logic                           BUSY,
  output logic                           CMD_ERR
);

  localparam int IDX_W = (OUT_BYTES > 0) ? $clog2(OUT_BYTES + 1) : 1;

  localparam logic [FRAME_WIDTH-1:0] CMD_WR     = FRAME_WIDTH'(8'hAA);
  localparam logic [FRAME_WIDTH-1:0] CMD_RD     = FRAME_WIDTH'(8'hBB);
  localparam logic [FRAME_WIDTH-1:0] CMD_ALU    = FRAME_WIDTH'(8'hCC);
  localparam logic [FRAME_WIDTH-1:0] CMD_ALU_NO = FRAME_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FN, ALU_WAIT, TX
  } state_t;

  state_t                         state_reg, state_next;
  logic [REG_FILE_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ALU_DATA_WIDTH-1:0]      buf_reg, buf_next;
  logic [IDX_W-1:0]               cnt_reg, cnt_next;
  logic [IDX_W-1:0]               idx_reg, idx_next;

  logic [ALU_FUNC_WIDTH-1:0]      alu_func_reg, alu_func_next;
  logic                           alu_en_reg, alu_en_next;
  logic                           clk_en_reg, clk_en_next;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_addr_reg, rf_addr_next;
  logic                           wr_en_reg, wr_en_next;
  logic                           rd_en_reg, rd_en_next;
  logic [FRAME_WIDTH-1:0]         wr_data_reg, wr_data_next;
  logic                           wr_inc_reg, wr_inc_next;
  logic                           clk_div_en_reg;
  logic                           busy_reg, busy_next;
  logic                           cmd_err_reg, cmd_err_next;

  logic                           timeout_hit;

  // Result buffer viewed as an array of frames, LSB frame at index 0.
  logic [FRAME_WIDTH-1:0] tx_frames [OUT_BYTES];
  logic [FRAME_WIDTH-1:0] tx_frame;

  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_frames
    assign tx_frames[gi] = buf_reg[gi*FRAME_WIDTH +: FRAME_WIDTH];
  end

  always_comb begin
    tx_frame = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (idx_reg == IDX_W'(i)) tx_frame = tx_frames[i];
    end
  end

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_reg;
  logic             tmo_counting;
  logic             tmo_strobe;

  assign tmo_counting = (state_reg != IDLE) && (state_reg != TX);
  assign tmo_strobe   = RX_P_VLD || RdData_Valid || OUT_VALID;
  assign timeout_hit  = tmo_counting && !tmo_strobe && (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST || !tmo_counting || tmo_strobe || timeout_hit) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end
`else
  // Waiting states block indefinitely; TIMEOUT_CYCLES only matters with the timeout build.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    buf_next      = buf_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    alu_func_next = alu_func_reg;
    alu_en_next   = 1'b0;
    clk_en_next   = clk_en_reg;
    rf_addr_next  = rf_addr_reg;
    wr_en_next    = 1'b0;
    rd_en_next    = 1'b0;
    wr_data_next  = wr_data_reg;
    wr_inc_next   = 1'b0;
    cmd_err_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_P_VLD) begin
          case (RX_P_DATA)
            CMD_WR:     state_next = WR_ADDR;
            CMD_RD:     state_next = RD_ADDR;
            CMD_ALU:    state_next = OP_A;
            CMD_ALU_NO: state_next = OP_FN;
            default:    cmd_err_next = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_P_VLD) begin
          addr_next  = RX_P_DATA[REG_FILE_ADDR_WIDTH-1:0];
          state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_P_VLD) begin
          wr_en_next   = 1'b1;
          rf_addr_next = addr_reg;
          wr_data_next = RX_P_DATA;
          state_next   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_P_VLD) begin
          rd_en_next   = 1'b1;
          rf_addr_next = RX_P_DATA[REG_FILE_ADDR_WIDTH-1:0];
          state_next   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cmd_err_next = RX_P_VLD;
        if (RdData_Valid) begin
          buf_next   = ALU_DATA_WIDTH'(RdData);
          cnt_next   = IDX_W'(1);
          idx_next   = '0;
          state_next = TX;
        end
      end
      OP_A: begin
        if (RX_P_VLD) begin
          wr_en_next   = 1'b1;
          rf_addr_next = REG_FILE_ADDR_WIDTH'(OPA_ADDR);
          wr_data_next = RX_P_DATA;
          state_next   = OP_B;
        end
      end
      OP_B: begin
        if (RX_P_VLD) begin
          wr_en_next   = 1'b1;
          rf_addr_next = REG_FILE_ADDR_WIDTH'(OPB_ADDR);
          wr_data_next = RX_P_DATA;
          state_next   = OP_FN;
        end
      end
      OP_FN: begin
        if (RX_P_VLD) begin
          alu_func_next = RX_P_DATA[ALU_FUNC_WIDTH-1:0];
          alu_en_next   = 1'b1;
          clk_en_next   = 1'b1;
          state_next    = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        cmd_err_next = RX_P_VLD;
        if (OUT_VALID) begin
          buf_next    = ALU_OUT;
          cnt_next    = IDX_W'(OUT_BYTES);
          idx_next    = '0;
          clk_en_next = 1'b0;
          state_next  = TX;
        end
      end
      TX: begin
        cmd_err_next = RX_P_VLD;
        // A full FIFO freezes the index, so the pending frame is simply re-offered.
        if (!FIFO_FULL) begin
          wr_inc_next  = 1'b1;
          wr_data_next = tx_frame;
          if (idx_reg == cnt_reg - IDX_W'(1)) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (timeout_hit) begin
      state_next   = IDLE;
      cmd_err_next = 1'b1;
      clk_en_next  = 1'b0;
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      buf_reg        <= '0;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      alu_func_reg   <= '0;
      alu_en_reg     <= 1'b0;
      clk_en_reg     <= 1'b0;
      rf_addr_reg    <= '0;
      wr_en_reg      <= 1'b0;
      rd_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
      wr_inc_reg     <= 1'b0;
      clk_div_en_reg <= 1'b0;
      busy_reg       <= 1'b0;
      cmd_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      buf_reg        <= buf_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      alu_func_reg   <= alu_func_next;
      alu_en_reg     <= alu_en_next;
      clk_en_reg     <= clk_en_next;
      rf_addr_reg    <= rf_addr_next;
      wr_en_reg      <= wr_en_next;
      rd_en_reg      <= rd_en_next;
      wr_data_reg    <= wr_data_next;
      wr_inc_reg     <= wr_inc_next;
      clk_div_en_reg <= 1'b1;
      busy_reg       <= busy_next;
      cmd_err_reg    <= cmd_err_next;
    end
  end

  assign ALU_FUNC   = alu_func_reg;
  assign ALU_EN     = alu_en_reg;
  assign CLK_EN     = clk_en_reg;
  assign RF_ADDR    = rf_addr_reg;
  assign WrEn       = wr_en_reg;
  assign RdEn       = rd_en_reg;
  assign WrData     = wr_data_reg;
  assign WR_INC     = wr_inc_reg;
  assign clk_div_en = clk_div_en_reg;
  assign BUSY       = busy_reg;
  assign CMD_ERR    = cmd_err_reg;

endmodule

// File: tb/tb_sys_ctrl_mb.sv
// Directed self-checking bench for sys_ctrl_mb; define SYS_CTRL_TIMEOUT_EN to add the timeout scenario.
module tb_sys_ctrl_mb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_P_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [3:0]  ALU_FUNC;
  logic        ALU_EN, CLK_EN, WrEn, RdEn, WR_INC, clk_div_en, BUSY, CMD_ERR;
  logic [3:0]  RF_ADDR;
  logic [7:0]  WrData;

  int tests = 0;
  int fails = 0;

  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [3:0]  alu_q[$];
  int          full_push = 0;
  logic        full_at_edge;

  sys_ctrl_mb #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_P_VLD(RX_P_VLD),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .FIFO_FULL(FIFO_FULL), .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
    .RF_ADDR(RF_ADDR), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .WR_INC(WR_INC),
    .clk_div_en(clk_div_en), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Transaction monitor: one line per observed pulse.
  always @(posedge CLK) begin
    full_at_edge = FIFO_FULL;
    #1;
    if (WrEn)   begin wr_q.push_back({RF_ADDR, WrData}); $display("[TB] rf write addr=%0h data=%02h", RF_ADDR, WrData); end
    if (RdEn)   begin rd_q.push_back(RF_ADDR); $display("[TB] rf read addr=%0h", RF_ADDR); end
    if (ALU_EN) begin alu_q.push_back(ALU_FUNC); $display("[TB] alu start func=%0h", ALU_FUNC); end
    if (WR_INC) begin
      tx_q.push_back(WrData);
      $display("[TB] fifo push data=%02h", WrData);
      if (full_at_edge) full_push++;
    end
    if (CMD_ERR) $display("[TB] cmd_err pulse");
  end

  task automatic clear_q();
    wr_q.delete(); rd_q.delete(); tx_q.delete(); alu_q.delete();
  endtask

  // Called at a negedge; consecutive calls give gap-free strobes.
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_P_VLD  = 1'b1;
    @(negedge CLK);
    RX_P_VLD  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    tests++; if ({ALU_FUNC, ALU_EN, CLK_EN, RF_ADDR, WrEn, RdEn, WrData, WR_INC, clk_div_en, BUSY, CMD_ERR} !== 27'd0) begin
      fails++; $display("FAIL reset_outputs got=%h exp=0", {ALU_FUNC, ALU_EN, CLK_EN, RF_ADDR, WrEn, RdEn, WrData, WR_INC, clk_div_en, BUSY, CMD_ERR}); end
    RST = 1'b0;
    @(negedge CLK);
    tests++; if (clk_div_en !== 1'b1) begin fails++; $display("FAIL clk_div_en got=%b exp=1", clk_div_en); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_write();
    clear_q();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    tests++; if ({WrEn, RF_ADDR, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
      fails++; $display("FAIL write_pulse got=%b/%h/%h exp=1/5/3c", WrEn, RF_ADDR, WrData); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL write_busy got=%b exp=0", BUSY); end
    repeat (2) @(negedge CLK);
    tests++; if (wr_q.size() !== 1) begin fails++; $display("FAIL write_count got=%0d exp=1", wr_q.size()); end
  endtask

  task automatic test_read();
    clear_q();
    send_byte(8'hBB); send_byte(8'h07);
    tests++; if ({RdEn, RF_ADDR} !== {1'b1, 4'h7}) begin fails++; $display("FAIL read_pulse got=%b/%h exp=1/7", RdEn, RF_ADDR); end
    @(negedge CLK);
    tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL read_wait_busy got=%b exp=1", BUSY); end
    RdData = 8'hA5; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    tests++; if (rd_q.size() !== 1) begin fails++; $display("FAIL read_count got=%0d exp=1", rd_q.size()); end
    tests++; if (tx_q.size() !== 1 || tx_q[0] !== 8'hA5) begin fails++; $display("FAIL read_tx got=%0d/%h exp=1/a5", tx_q.size(), tx_q[0]); end
  endtask

  task automatic test_alu();
    clear_q();
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    tests++; if ({ALU_EN, CLK_EN, ALU_FUNC} !== {1'b1, 1'b1, 4'h0}) begin
      fails++; $display("FAIL alu_start got=%b/%b/%h exp=1/1/0", ALU_EN, CLK_EN, ALU_FUNC); end
    @(negedge CLK);
    tests++; if ({ALU_EN, CLK_EN} !== 2'b01) begin fails++; $display("FAIL alu_hold got=%b%b exp=01", ALU_EN, CLK_EN); end
    @(negedge CLK);
    ALU_OUT = 16'h0046; OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    tests++; if (CLK_EN !== 1'b0) begin fails++; $display("FAIL alu_clk_en_drop got=%b exp=0", CLK_EN); end
    repeat (4) @(negedge CLK);
    tests++; if (wr_q.size() !== 2 || wr_q[0] !== 12'h012 || wr_q[1] !== 12'h134) begin
      fails++; $display("FAIL alu_operands got=%0d/%h/%h exp=2/012/134", wr_q.size(), wr_q[0], wr_q[1]); end
    tests++; if (alu_q.size() !== 1) begin fails++; $display("FAIL alu_en_count got=%0d exp=1", alu_q.size()); end
    tests++; if (tx_q.size() !== 2 || tx_q[0] !== 8'h46 || tx_q[1] !== 8'h00) begin
      fails++; $display("FAIL alu_tx got=%0d/%h/%h exp=2/46/00", tx_q.size(), tx_q[0], tx_q[1]); end
  endtask

  task automatic test_fifo_full();
    clear_q();
    full_push = 0;
    send_byte(8'hDD); send_byte(8'h02);
    @(negedge CLK);
    ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1; FIFO_FULL = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    tests++; if (tx_q.size() !== 0) begin fails++; $display("FAIL full_stall got=%0d exp=0", tx_q.size()); end
    FIFO_FULL = 1'b0;
    repeat (4) @(negedge CLK);
    tests++; if (alu_q.size() !== 1 || alu_q[0] !== 4'h2) begin fails++; $display("FAIL full_func got=%0d/%h exp=1/2", alu_q.size(), alu_q[0]); end
    tests++; if (full_push !== 0) begin fails++; $display("FAIL full_push got=%0d exp=0", full_push); end
    tests++; if (tx_q.size() !== 2 || tx_q[0] !== 8'hEF || tx_q[1] !== 8'hBE) begin
      fails++; $display("FAIL full_tx got=%0d/%h/%h exp=2/ef/be", tx_q.size(), tx_q[0], tx_q[1]); end
  endtask

  task automatic test_cmd_err();
    clear_q();
    send_byte(8'h77);
    tests++; if ({CMD_ERR, BUSY} !== 2'b10) begin fails++; $display("FAIL bad_cmd got=%b%b exp=10", CMD_ERR, BUSY); end
    @(negedge CLK);
    tests++; if (CMD_ERR !== 1'b0) begin fails++; $display("FAIL bad_cmd_pulse got=%b exp=0", CMD_ERR); end
    // A command value arriving during ALU_WAIT is dropped.
    send_byte(8'hDD); send_byte(8'h03);
    @(negedge CLK);
    send_byte(8'hCC);
    tests++; if ({CMD_ERR, BUSY, CLK_EN} !== 3'b111) begin fails++; $display("FAIL drop_in_wait got=%b%b%b exp=111", CMD_ERR, BUSY, CLK_EN); end
    ALU_OUT = 16'h1234; OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    @(negedge CLK);
    tests++; if ({WR_INC, WrData} !== {1'b1, 8'h34}) begin fails++; $display("FAIL tx_first got=%b/%h exp=1/34", WR_INC, WrData); end
    FIFO_FULL = 1'b1;
    @(negedge CLK);
    tests++; if ({WR_INC, BUSY} !== 2'b01) begin fails++; $display("FAIL last_full_stall got=%b%b exp=01", WR_INC, BUSY); end
    @(negedge CLK);
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    tests++; if ({WR_INC, WrData, BUSY} !== {1'b1, 8'h12, 1'b0}) begin
      fails++; $display("FAIL tx_last got=%b/%h/%b exp=1/12/0", WR_INC, WrData, BUSY); end
    tests++; if (wr_q.size() !== 0 || tx_q.size() !== 2) begin fails++; $display("FAIL drop_side got=%0d/%0d exp=0/2", wr_q.size(), tx_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_byte(8'hAA); send_byte(8'h09); send_byte(8'h55); send_byte(8'hBB); send_byte(8'h09);
    @(negedge CLK);
    RdData = 8'hC3; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    @(negedge CLK);
    tests++; if ({WR_INC, WrData} !== {1'b1, 8'hC3}) begin fails++; $display("FAIL b2b_tx got=%b/%h exp=1/c3", WR_INC, WrData); end
    send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h66);
    @(negedge CLK);
    tests++; if (wr_q.size() !== 2 || wr_q[0] !== 12'h955 || wr_q[1] !== 12'hA66) begin
      fails++; $display("FAIL b2b_writes got=%0d/%h/%h exp=2/955/a66", wr_q.size(), wr_q[0], wr_q[1]); end
    tests++; if (rd_q.size() !== 1 || rd_q[0] !== 4'h9) begin fails++; $display("FAIL b2b_read got=%0d/%h exp=1/9", rd_q.size(), rd_q[0]); end
  endtask

  task automatic test_reset_alu();
    clear_q();
    send_byte(8'hDD); send_byte(8'h01);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    tests++; if ({ALU_FUNC, ALU_EN, CLK_EN, RF_ADDR, WrEn, RdEn, WrData, WR_INC, clk_div_en, BUSY, CMD_ERR} !== 27'd0) begin
      fails++; $display("FAIL rst_alu_outputs got=%h exp=0", {ALU_FUNC, ALU_EN, CLK_EN, RF_ADDR, WrEn, RdEn, WrData, WR_INC, clk_div_en, BUSY, CMD_ERR}); end
    RST = 1'b0;
    @(negedge CLK);
    ALU_OUT = 16'hFFFF; OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    tests++; if (tx_q.size() !== 0) begin fails++; $display("FAIL rst_alu_tx got=%0d exp=0", tx_q.size()); end
    tests++; if ({BUSY, clk_div_en} !== 2'b01) begin fails++; $display("FAIL rst_alu_state got=%b%b exp=01", BUSY, clk_div_en); end
  endtask

`ifdef SYS_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    clear_q();
    send_byte(8'hAA);
    k = 0;
    while (k < 40 && CMD_ERR !== 1'b1) begin
      @(negedge CLK);
      k++;
    end
    tests++; if (k !== 16) begin fails++; $display("FAIL timeout_cycles got=%0d exp=16", k); end
    tests++; if ({BUSY, wr_q.size() == 0} !== 2'b01) begin fails++; $display("FAIL timeout_state got=%b/%0d exp=0/0", BUSY, wr_q.size()); end
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_fifo_full();
    test_cmd_err();
    test_back_to_back();
    test_reset_alu();
`ifdef SYS_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
